mem_arbiter: RTL

- Shares one unified single-port 2K x 32 SRAM between the core's instruction-fetch port and its data-access port.
- Grants at most one access per cycle. Routes read data back to the owner one cycle later.
- Raises a stall to the pipeline for any requester not granted this cycle.
- Sits between the RISC core and the testbench memory model, replacing the separate i-Mem and d-Mem.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_starve_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the unified-SRAM arbiter     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 11;
    localparam int MEM_DATA_W = 32;
    localparam int STARVE_CNT_W = 4;

    localparam logic CEN_OFF = 1'b1;
    localparam logic WEN_OFF = 1'b1;
    localparam logic OEN_OFF = 1'b1;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } resp_owner_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | arb_starve_counter : saturating count of data grants while fetch waits    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam logic [STARVE_CNT_W-1:0] c_LIMIT = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_limit = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_arbiter : fetch/data arbiter for one single-port SRAM, 1-cycle reads. |
// | Optional macro MEM_ARB_PERF_CNT_EN adds the perf_conflicts counter port.  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              core_stall,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]       perf_conflicts,
`endif
    input  logic [DATA_W-1:0] mem_dataout
);

    logic        w_at_limit;
    logic        w_i_wins;
    logic        w_any_gnt;
    resp_owner_t r_owner;
    resp_owner_t w_owner_nxt;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (i_req & d_gnt),
        .i_clr      (i_gnt | ~i_req),
        .o_at_limit (w_at_limit)
    );

    // Data has priority unless fetch has waited through STARVE_LIMIT data grants.
    assign w_i_wins  = i_req & w_at_limit;
    assign d_gnt     = ~rst & d_req & ~w_i_wins;
    assign i_gnt     = ~rst & i_req & (~d_req | w_i_wins);
    assign w_any_gnt = i_gnt | d_gnt;

    assign core_stall = (i_req & ~i_gnt) | (d_req & ~d_gnt);

    assign mem_cen    = w_any_gnt ? 1'b0 : CEN_OFF;
    assign mem_oen    = w_any_gnt ? 1'b0 : OEN_OFF;
    assign mem_wen    = (d_gnt & d_we) ? 1'b0 : WEN_OFF;
    assign mem_addr   = i_gnt ? i_addr : (d_gnt ? d_addr : '0);
    assign mem_datain = d_gnt ? d_wdata : '0;

    always_comb begin
        w_owner_nxt = NONE;
        if (i_gnt) begin
            w_owner_nxt = INST;
        end else if (d_gnt && !d_we) begin
            w_owner_nxt = DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    assign i_rvalid = (r_owner == INST);
    assign d_rvalid = (r_owner == DATA);
    assign i_rdata  = mem_dataout;
    assign d_rdata  = mem_dataout;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_conflicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_conflicts <= '0;
        end else if (i_req && d_req) begin
            r_perf_conflicts <= r_perf_conflicts + 32'd1;
        end
    end

    assign perf_conflicts = r_perf_conflicts;
`endif

endmodule
`default_nettype wire
